// File: rtl/hdmi_pattern_src.sv
// Video timing generator with a built-in test-pattern source (solid, gradient, bars, checker).
// Outputs are registered one cycle behind the raster counters; disabling always finishes the frame.
module hdmi_pattern_src #(
   parameter int horizontal_res = 64,
   parameter int vertical_res   = 64,
   parameter int h_fp           = 4,
   parameter int h_sync         = 4,
   parameter int h_bp           = 4,
   parameter int v_fp           = 2,
   parameter int v_sync         = 2,
   parameter int v_bp           = 2
) (
   input  logic        hdmi_clk,
   input  logic        hdmi_rst_n,
   input  logic        en,
   input  logic [1:0]  mode,
   input  logic [23:0] solid_rgb,
   output logic        hdmi_hs,
   output logic        hdmi_vs,
   output logic        hdmi_de,
   output logic [31:0] hdmi_data,
   output logic [7:0]  frame_cnt,
   output logic        busy
);

   localparam int HT = horizontal_res + h_fp + h_sync + h_bp;
   localparam int VT = vertical_res + v_fp + v_sync + v_bp;
   localparam int HW = $clog2(HT);
   localparam int VW = $clog2(VT);

   localparam logic [HW-1:0] H_ACT  = HW'(horizontal_res);
   localparam logic [HW-1:0] H_SS   = HW'(horizontal_res + h_fp);
   localparam logic [HW-1:0] H_SL   = HW'(horizontal_res + h_fp + h_sync - 1);
   localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(vertical_res);
   localparam logic [VW-1:0] V_SS   = VW'(vertical_res + v_fp);
   localparam logic [VW-1:0] V_SL   = VW'(vertical_res + v_fp + v_sync - 1);
   localparam logic [VW-1:0] V_LAST = VW'(VT - 1);
   localparam logic [HW+2:0] BAR_DIV = (HW+3)'(horizontal_res);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic [VW-1:0] vcnt_q, vcnt_d;
   logic [7:0]    frame_q, frame_d;
   logic [1:0]    mode_q, mode_d;
   logic [23:0]   rgb_q, rgb_d;
   logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d, busy_q, busy_d;
   logic [31:0]   data_q, data_d;

   logic          running, h_last, v_last, frame_end, frame_start;
   logic [1:0]    mode_eff;
   logic [23:0]   rgb_eff, pix;
   logic [7:0]    x8, y8;
   logic [2:0]    bar;
   logic          chk;

   always_comb begin
      running     = (state_q != ST_IDLE);
      h_last      = (hcnt_q == H_LAST);
      v_last      = (vcnt_q == V_LAST);
      frame_end   = running && h_last && v_last;
      frame_start = (state_q == ST_RUN) && (hcnt_q == '0) && (vcnt_q == '0);

      state_d = state_q;
      hcnt_d  = hcnt_q;
      vcnt_d  = vcnt_q;
      frame_d = frame_q;
      mode_d  = mode_q;
      rgb_d   = rgb_q;

      case (state_q)
         ST_IDLE:  if (en) state_d = ST_RUN;
         ST_RUN:   if (!en) state_d = ST_DRAIN;
         ST_DRAIN: begin
            if (en)             state_d = ST_RUN;
            else if (frame_end) state_d = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase

      if (running) begin
         if (h_last) begin
            hcnt_d = '0;
            vcnt_d = v_last ? '0 : vcnt_q + VW'(1);
         end else begin
            hcnt_d = hcnt_q + HW'(1);
         end
         if (frame_end) frame_d = frame_q + 8'd1;
      end

      // The pixel at frame start already uses the freshly sampled pattern settings.
      if (frame_start) begin
         mode_d = mode;
         rgb_d  = solid_rgb;
      end
   end

   always_comb begin
      mode_eff = frame_start ? mode : mode_q;
      rgb_eff  = frame_start ? solid_rgb : rgb_q;
      x8       = 8'(hcnt_q);
      y8       = 8'(vcnt_q);
      bar      = 3'({hcnt_q, 3'b000} / BAR_DIV);
      chk      = x8[3] ^ y8[3] ^ frame_q[0];

      case (mode_eff)
         2'd0:    pix = rgb_eff;
         2'd1:    pix = {x8, y8, frame_q};
         2'd2:    pix = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
         default: pix = {24{chk}};
      endcase

      de_d   = running && (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
      hs_d   = !(running && (hcnt_q >= H_SS) && (hcnt_q <= H_SL));
      vs_d   = !(running && (vcnt_q >= V_SS) && (vcnt_q <= V_SL));
      data_d = de_d ? {8'h00, pix} : 32'h0;
      busy_d = running;
   end

   always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
      if (!hdmi_rst_n) begin
         state_q <= ST_IDLE;
         hcnt_q  <= '0;
         vcnt_q  <= '0;
         frame_q <= 8'd0;
         mode_q  <= 2'd0;
         rgb_q   <= 24'h0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         de_q    <= 1'b0;
         data_q  <= 32'h0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hcnt_q  <= hcnt_d;
         vcnt_q  <= vcnt_d;
         frame_q <= frame_d;
         mode_q  <= mode_d;
         rgb_q   <= rgb_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         de_q    <= de_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
      end
   end

   assign hdmi_hs   = hs_q;
   assign hdmi_vs   = vs_q;
   assign hdmi_de   = de_q;
   assign hdmi_data = data_q;
   assign frame_cnt = frame_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_hdmi_pattern_src.sv
// Scoreboard bench for hdmi_pattern_src: a frame-position model predicts every output cycle,
// a monitor pops and compares, plus fixed-value checks for sync, bars, mode switch and reset.
module tb_hdmi_pattern_src;

   localparam int H = 64, V = 64;
   localparam int HT = 76, VT = 70, N = HT * VT;

   logic        clk = 1'b0;
   logic        rst_n, en;
   logic [1:0]  mode;
   logic [23:0] solid_rgb;
   logic        hdmi_hs, hdmi_vs, hdmi_de, busy;
   logic [31:0] hdmi_data;
   logic [7:0]  frame_cnt;

   always #5 clk = ~clk;

   hdmi_pattern_src #(
      .horizontal_res(64), .vertical_res(64),
      .h_fp(4), .h_sync(4), .h_bp(4), .v_fp(2), .v_sync(2), .v_bp(2)
   ) dut (
      .hdmi_clk(clk), .hdmi_rst_n(rst_n), .en(en), .mode(mode), .solid_rgb(solid_rgb),
      .hdmi_hs(hdmi_hs), .hdmi_vs(hdmi_vs), .hdmi_de(hdmi_de), .hdmi_data(hdmi_data),
      .frame_cnt(frame_cnt), .busy(busy)
   );

   // v = {hs, vs, de, busy, frame_cnt, data}
   typedef struct {
      logic [43:0] v;
      int          x, y, fr, md;
      bit          on;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   bit   phase_b = 0;

   bit          m_on, m_drain;
   int          m_pos, m_fc, m_mode;
   logic [23:0] m_rgb;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         if (bad <= 40) $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic mdl_reset();
      m_on = 0; m_drain = 0; m_pos = 0; m_fc = 0; m_mode = 0; m_rgb = 24'h0;
   endtask

   function automatic exp_t idle_exp(input int fc);
      exp_t e;
      e.v = {1'b1, 1'b1, 1'b0, 1'b0, 8'(fc), 32'h0};
      e.x = -1; e.y = -1; e.fr = fc; e.md = -1; e.on = 0;
      return e;
   endfunction

   function automatic logic [23:0] pix(input int md, input logic [23:0] rgb,
                                       input int x, input int y, input int fc);
      int b;
      case (md)
         0: return rgb;
         1: return {8'(x), 8'(y), 8'(fc)};
         2: begin
            b = (x * 8) / H;
            return {{8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
         end
         default: return ((x / 8 + y / 8 + fc) % 2 == 1) ? 24'hFFFFFF : 24'h0;
      endcase
   endfunction

   // Reference: a frame is a linear walk over N positions; outputs lag one cycle.
   always @(posedge clk) begin
      exp_t e;
      int x, y, md;
      logic [23:0] rgb;
      logic hs_e, vs_e, de_e;
      logic [31:0] d_e;
      bit fs;
      if (!rst_n) begin
         mdl_reset();
         q.push_back(idle_exp(0));
      end else begin
         x = m_pos % HT;
         y = m_pos / HT;
         fs = m_on && !m_drain && (m_pos == 0);
         md = fs ? int'(mode) : m_mode;
         rgb = fs ? solid_rgb : m_rgb;
         if (m_on) begin
            de_e = (x < H) && (y < V);
            hs_e = !(x >= H + 4 && x < H + 8);
            vs_e = !(y >= V + 2 && y < V + 4);
            d_e  = de_e ? {8'h00, pix(md, rgb, x, y, m_fc)} : 32'h0;
         end else begin
            de_e = 0; hs_e = 1; vs_e = 1; d_e = 32'h0;
         end
         e.x = x; e.y = y; e.fr = m_fc; e.md = md; e.on = m_on;
         if (fs) begin
            m_mode = int'(mode);
            m_rgb  = solid_rgb;
         end
         if (!m_on) begin
            if (en) begin m_on = 1; m_drain = 0; m_pos = 0; end
         end else begin
            if (m_pos == N - 1) begin
               m_fc = (m_fc + 1) % 256;
               if (m_drain && !en) m_on = 0;
            end
            m_pos = (m_pos + 1) % N;
            m_drain = !en;
         end
         e.v = {hs_e, vs_e, de_e, e.on, 8'(m_fc), d_e};
         q.push_back(e);
      end
   end

   int          cyc = 0, de_cnt = 0, last_chg = -1;
   logic [7:0]  prev_fc = 8'd0;

   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (q.size() == 0) begin
         total++; bad++;
         $display("FAIL scoreboard_empty: got no expectation at t=%0t required one", $time);
      end else begin
         e = q.pop_front();
         check("outputs", {20'h0, hdmi_hs, hdmi_vs, hdmi_de, busy, frame_cnt, hdmi_data}, {20'h0, e.v});
         if (e.on) begin
            if (e.x >= 68 && e.x <= 71) check("hs_low_68_71", hdmi_hs, 0);
            if (e.y == 66 || e.y == 67) check("vs_low_66_67", hdmi_vs, 0);
            if (e.x == 0 && e.y == 0) check("first_de_after_00", hdmi_de, 1);
            if (e.md == 2 && e.y == 0 && e.x < 8) check("bar_x0_7", hdmi_data, 32'h000000);
            if (e.md == 2 && e.y == 0 && e.x >= 8 && e.x < 16) check("bar_x8_15", hdmi_data, 32'h0000FF);
            if (e.md == 2 && e.y == 0 && e.x >= 56 && e.x < 64) check("bar_x56_63", hdmi_data, 32'h00FFFFFF);
            if (phase_b && e.fr == 3 && e.x == 1 && e.y == 15) check("solid_holds", hdmi_data, 32'h00123456);
            if (phase_b && e.fr == 4 && e.x == 5 && e.y == 3) check("gradient_5_3", hdmi_data, 32'h00050304);
         end
      end
      if (!rst_n) begin
         de_cnt = 0; last_chg = -1; prev_fc = 8'd0;
      end else begin
         if (busy !== 1'b1) last_chg = -1;
         if (hdmi_de === 1'b1) de_cnt++;
         if (frame_cnt !== prev_fc) begin
            check("frame_cnt_step", frame_cnt, 8'(prev_fc + 8'd1));
            check("de_per_frame", de_cnt, 4096);
            if (last_chg >= 0) check("frame_period", cyc - last_chg, 5320);
            $display("frame %0d complete at cycle %0d, de cycles %0d", frame_cnt, cyc, de_cnt);
            last_chg = cyc; de_cnt = 0; prev_fc = frame_cnt;
         end
      end
   end

   task automatic wait_frame(input int f);
      int n = 0;
      while (m_fc != f && n < 12000) begin @(negedge clk); n++; end
      if (m_fc != f) begin
         total++; bad++;
         $display("FAIL wait_frame: got frame %0d required %0d", m_fc, f);
      end
   endtask

   task automatic wait_line(input int y);
      int n = 0;
      while (!(m_on && m_pos == y * HT) && n < 6000) begin @(negedge clk); n++; end
      if (!(m_on && m_pos == y * HT)) begin
         total++; bad++;
         $display("FAIL wait_line: got pos %0d required line %0d", m_pos, y);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (m_on && n < 12000) begin @(negedge clk); n++; end
      repeat (2) @(negedge clk);
      check("idle_busy", busy, 0);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      en = 0; mode = 2'd2; solid_rgb = 24'h0; rst_n = 1;
      #1 rst_n = 0;
      repeat (3) @(negedge clk);
      rst_n = 1;
      repeat (3) @(negedge clk);

      // Two bar frames from idle, then solid, then gradient switched mid-frame.
      en = 1;
      wait_frame(2);
      phase_b = 1;
      wait_line(5);
      mode = 2'd0; solid_rgb = 24'h123456;
      wait_frame(3);
      wait_line(10);
      mode = 2'd1;
      wait_frame(4);
      wait_line(30);
      mode = 2'd2;
      wait_frame(5);
      phase_b = 0;

      // Disable and re-enable inside one frame, then a clean stop.
      wait_line(20); en = 0;
      wait_line(60); en = 1;
      wait_frame(6);
      wait_line(20); en = 0;
      wait_idle();
      repeat (20) @(negedge clk);

      // Reset in the middle of a checkerboard frame.
      mode = 2'd3; en = 1;
      wait_frame(7);
      wait_line(30);
      @(posedge clk);
      #2 rst_n = 0;
      #1;
      check("reset_outputs", {20'h0, hdmi_hs, hdmi_vs, hdmi_de, busy, frame_cnt, hdmi_data},
            {20'h0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0});
      check("reset_frame_cnt", frame_cnt, 0);
      q.delete();
      mdl_reset();
      q.push_back(idle_exp(0));
      en = 0;
      repeat (4) @(negedge clk);
      rst_n = 1;
      repeat (50) @(negedge clk);
      en = 1;
      wait_frame(1);

      // Random pattern, colour and enable activity.
      for (int i = 0; i < 60; i++) begin
         repeat ($urandom_range(100, 600)) @(negedge clk);
         r = $urandom_range(0, 9);
         if (r < 4)      mode = 2'($urandom);
         else if (r < 6) solid_rgb = 24'($urandom);
         else            en = ~en;
      end
      en = 0;
      wait_idle();
      repeat (10) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hdmi_pattern_src.md
HDMI_PATTERN_SRC -- requirements
Module: hdmi_pattern_src

Interface
REQ-001 Parameter horizontal_res, default 64: active pixels per line.
REQ-002 Parameter vertical_res, default 64: active lines per frame.
REQ-003 Parameters h_fp, h_sync, h_bp, defaults 4/4/4: horizontal front porch, sync and back porch, in pixel clocks.
REQ-004 Parameters v_fp, v_sync, v_bp, defaults 2/2/2: vertical front porch, sync and back porch, in lines.
REQ-005 hdmi_clk  in  1: pixel clock; the single clock of the block.
REQ-006 hdmi_rst_n  in  1: reset, asynchronous, active-low.
REQ-007 en  in  1: run request.
REQ-008 mode  in  2: pattern select. 0 = solid, 1 = gradient, 2 = colour bars, 3 = checkerboard.
REQ-009 solid_rgb  in  24: colour used in mode 0, as {R,G,B}.
REQ-010 hdmi_hs  out  1: horizontal sync, active-low.
REQ-011 hdmi_vs  out  1: vertical sync, active-low.
REQ-012 hdmi_de  out  1: data enable, high on active pixels.
REQ-013 hdmi_data  out  32: pixel data. {8'h00, R[23:16], G[15:8], B[7:0]}.
REQ-014 frame_cnt  out  8: number of completed frames, wraps.
REQ-015 busy  out  1: high while a frame is in progress.

Function
REQ-016 Horizontal counter hcnt SHALL run from 0 to HT-1, where HT = horizontal_res+h_fp+h_sync+h_bp (76 with defaults), then wrap to 0.
- Order within a line: active, FP, sync, BP.
REQ-017 Vertical counter vcnt SHALL advance by one when hcnt wraps, and SHALL wrap at VT-1, where VT = vertical_res+v_fp+v_sync+v_bp (70 with defaults).
- Order within a frame: active, FP, sync, BP.
REQ-018 Counter widths SHALL be clog2 of HT and VT respectively; no overflow is permitted for any legal parameter set.
REQ-019 hdmi_de SHALL be 1 exactly when hcnt < horizontal_res and vcnt < vertical_res.
REQ-020 hdmi_hs SHALL be 0 exactly when hcnt is in [horizontal_res+h_fp, horizontal_res+h_fp+h_sync-1]; this applies on every line.
REQ-021 hdmi_vs SHALL be 0 for the whole of lines vcnt in [vertical_res+v_fp, vertical_res+v_fp+v_sync-1].
REQ-022 All outputs SHALL be registered, with exactly 1 cycle latency from the counter state; hs, vs, de and data SHALL stay mutually aligned.
REQ-023 Pixel coordinates x = hcnt and y = vcnt.
- Mode 0: data = solid_rgb.
- Mode 1: R = x[7:0], G = y[7:0], B = frame_cnt.
- Mode 2: bar index b = (x*8)/horizontal_res; R = {8{b[2]}}, G = {8{b[1]}}, B = {8{b[0]}}.
- Mode 3: all channels = 8'hFF if x[3]^y[3]^frame_cnt[0], else 8'h00.
REQ-024 When hdmi_de = 0, hdmi_data SHALL be 32'h0.
REQ-025 mode and solid_rgb SHALL be sampled only at frame start (hcnt = 0, vcnt = 0, in RUN). A mid-frame change SHALL take effect from the next frame.
REQ-026 The FSM SHALL have three states, IDLE, RUN and DRAIN:
- IDLE -> RUN when en = 1; counters start from 0 on the following cycle.
- RUN -> DRAIN when en = 0.
- DRAIN -> IDLE on the cycle the last pixel of the frame is counted (hcnt = HT-1, vcnt = VT-1). If en returns to 1 during DRAIN, the next state SHALL be RUN instead, with no gap.
REQ-027 In IDLE, counters SHALL hold at 0, hs = 1, vs = 1, de = 0, data = 0 and busy = 0. In RUN and DRAIN, busy = 1.
REQ-028 frame_cnt SHALL increment on each completed frame (the hcnt = HT-1, vcnt = VT-1 wrap), including the final frame of DRAIN, and SHALL wrap 255 -> 0.
REQ-029 An aborted frame SHALL NOT occur except by reset: disabling always completes the current frame.

Reset
REQ-030 On hdmi_rst_n = 0, asynchronously: state = IDLE, hcnt = 0, vcnt = 0, frame_cnt = 0, hdmi_hs = 1, hdmi_vs = 1, hdmi_de = 0, hdmi_data = 0, busy = 0, sampled mode = 0, sampled solid_rgb = 0.
REQ-031 Reset asserted mid-frame SHALL truncate the frame immediately, with no frame_cnt increment. After release the block SHALL remain in IDLE until en is sampled high.

Verification
REQ-032 Defaults, mode 2, en held 1 for 2 frames -> 64 de cycles per line; 4096 de cycles per frame; frame period 5320 clocks; frame_cnt 0 -> 1 -> 2.
REQ-033 Check hs and vs timing -> hs low for hcnt 68..71 on every line; vs low for lines 66..67; first de falls 1 clock after counter (0,0).
REQ-034 Mode 2, line 0 -> pixels x = 0..7 data 32'h000000; x = 8..15 data 32'h0000FF; x = 56..63 data 32'hFFFFFF.
REQ-035 Mode changed 0 -> 1 at vcnt = 10 -> current frame stays solid_rgb (32'h00123456 for solid_rgb = 24'h123456); next frame pixel (5,3) = {8'h00, 8'h05, 8'h03, frame_cnt}.
REQ-036 en dropped at vcnt = 20, then en re-raised at vcnt = 60 -> frame completes with no gap; next frame starts the following clock; busy stays 1 throughout. Separately, en dropped with no re-raise -> IDLE after last pixel; busy = 0; hs = vs = 1.
REQ-037 hdmi_rst_n pulsed low at vcnt = 30 -> all outputs at reset values in the same cycle; frame_cnt = 0; no de until en is high.
